shift_sched: RTL

Two-requester round-robin scheduler and 2-stage pipeline wrapper around the shared 64-bit logical right barrel shifter. Two clients in the execute and address-generation paths share one shifter instance without duplicating it. The block arbitrates requests, registers operands, drives the shifter, and returns each tagged result on a single valid/ready response channel with back-pressure.

---
 rtl/shift_sched_if.sv | 26 ++
 rtl/shift_sched.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/shift_sched_if.sv
// Request/response bundle between the two shift clients, the scheduler and the result consumer.
interface shift_sched_if #(
    parameter int ID_W = 1
);
    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [63:0]     req_data0;
    logic [63:0]     req_data1;
    logic [5:0]      req_shamt0;
    logic [5:0]      req_shamt1;
    logic [1:0]      req_dir;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [63:0]     rsp_data;

    modport master (
        output req_valid, req_data0, req_data1, req_shamt0, req_shamt1, req_dir, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_data0, req_data1, req_shamt0, req_shamt1, req_dir, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );
endinterface

// File: rtl/shift_sched.sv
// Two-requester round-robin scheduler feeding one shared 64-bit logical shifter through an
// operand stage (A) and a result stage (B). Define SHIFT_SCHED_LSL_EN to add left shifts.
module shift_sched #(
    parameter int ID_W = 1
) (
    input  logic         clk,
    input  logic         reset,
    shift_sched_if.slave bus
);
    logic            rr_q, rr_d;
    logic            a_vld_q, a_vld_d;
    logic [63:0]     a_data_q, a_data_d;
    logic [5:0]      a_shamt_q, a_shamt_d;
    logic [ID_W-1:0] a_id_q, a_id_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [63:0]     rsp_data_q, rsp_data_d;
    logic [ID_W-1:0] rsp_id_q, rsp_id_d;

    logic            b_free_s;
    logic            a_free_s;
    logic            gnt_any_s;
    logic            gnt_id_s;
    logic            accept_s;
    logic            advance_s;
    logic [1:0]      req_ready_s;
    logic [63:0]     shift_out_s;

`ifdef SHIFT_SCHED_LSL_EN
    logic            a_dir_q, a_dir_d;
    logic [63:0]     sh_in_s;
    logic [63:0]     sh_raw_s;

    function automatic logic [63:0] bit_rev64(input logic [63:0] v);
        logic [63:0] r;
        r = 64'h0;
        for (int i = 0; i < 64; i++) begin
            r[i] = v[63 - i];
        end
        return r;
    endfunction
`else
    logic [1:0]      unused_dir_s;
    assign unused_dir_s = bus.req_dir;
`endif

    // Stall chain, round-robin grant and per-requester accept; nothing is accepted during reset
    always_comb begin
        b_free_s  = ~rsp_valid_q | bus.rsp_ready;
        a_free_s  = ~a_vld_q | b_free_s;
        gnt_any_s = |bus.req_valid;
        case (bus.req_valid)
            2'b01:   gnt_id_s = 1'b0;
            2'b10:   gnt_id_s = 1'b1;
            2'b11:   gnt_id_s = rr_q;
            default: gnt_id_s = rr_q;
        endcase
        accept_s  = gnt_any_s & a_free_s & reset;
        advance_s = a_vld_q & b_free_s;
        if (accept_s) begin
            req_ready_s = gnt_id_s ? 2'b10 : 2'b01;
        end else begin
            req_ready_s = 2'b00;
        end
    end

    // Next state of the priority pointer and the operand stage
    always_comb begin
        rr_d      = rr_q;
        a_vld_d   = a_free_s ? accept_s : a_vld_q;
        a_data_d  = a_data_q;
        a_shamt_d = a_shamt_q;
        a_id_d    = a_id_q;
`ifdef SHIFT_SCHED_LSL_EN
        a_dir_d   = a_dir_q;
`endif
        if (accept_s) begin
            rr_d      = ~gnt_id_s;
            a_data_d  = gnt_id_s ? bus.req_data1 : bus.req_data0;
            a_shamt_d = gnt_id_s ? bus.req_shamt1 : bus.req_shamt0;
            a_id_d    = ID_W'(gnt_id_s);
`ifdef SHIFT_SCHED_LSL_EN
            a_dir_d   = bus.req_dir[gnt_id_s];
`endif
        end else begin
            rr_d      = rr_q;
        end
    end

    // Shared shifter; a left shift is a right shift wrapped in bit reversals
    always_comb begin
`ifdef SHIFT_SCHED_LSL_EN
        sh_in_s     = a_dir_q ? bit_rev64(a_data_q) : a_data_q;
        sh_raw_s    = sh_in_s >> a_shamt_q;
        shift_out_s = a_dir_q ? bit_rev64(sh_raw_s) : sh_raw_s;
`else
        shift_out_s = a_data_q >> a_shamt_q;
`endif
    end

    // Next state of the result stage; a held result never changes until taken
    always_comb begin
        rsp_valid_d = b_free_s ? a_vld_q : rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        if (advance_s) begin
            rsp_data_d = shift_out_s;
            rsp_id_d   = a_id_q;
        end else begin
            rsp_data_d = rsp_data_q;
        end
    end

    // State and pipeline registers; reset discards anything in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_q        <= 1'b0;
            a_vld_q     <= 1'b0;
            a_data_q    <= 64'h0;
            a_shamt_q   <= 6'd0;
            a_id_q      <= {ID_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 64'h0;
            rsp_id_q    <= {ID_W{1'b0}};
`ifdef SHIFT_SCHED_LSL_EN
            a_dir_q     <= 1'b0;
`endif
        end else begin
            rr_q        <= rr_d;
            a_vld_q     <= a_vld_d;
            a_data_q    <= a_data_d;
            a_shamt_q   <= a_shamt_d;
            a_id_q      <= a_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef SHIFT_SCHED_LSL_EN
            a_dir_q     <= a_dir_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_s;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_id    = rsp_id_q;
endmodule
